decode_redirect: RTL
====================

// Module: decode_redirect
// PURPOSE
//  Consumer end of the fetch interface: captures InstrD/PCD/PCPlus4D into the D/E pipeline register and
//  pre-computes the control-flow target. Resolves jumps and branches in E and drives PCSrcE/PCTargetE
//  back to fetch. Fetch has no flush input, so this block squashes the wrong-path slots itself.
// PARAMETERS
//  XLEN          27  instruction / PC width
//  SQUASH_SLOTS   2  wrong-path D slots discarded per redirect (redirect cycle + following ones)
//  CNT_W         16  width of debug event counters
// PORTS
//  clk              in   1     clock, rising edge
//  rst              in   1     asynchronous, active-low reset
//  InstrD           in   XLEN  instruction from fetch D stage
//  PCD              in   XLEN  PC of InstrD
//  PCPlus4D         in   XLEN  PCD+4 from fetch
//  ZeroE            in   1     ALU zero flag for the instruction in E (combinational from execute)
//  PCSrcE           out  1     redirect request to fetch
//  PCTargetE        out  XLEN  redirect target to fetch
//  InstrE           out  XLEN  D/E register: instruction (0 when bubble)
//  PCE              out  XLEN  D/E register: PC
//  PCPlus4E         out  XLEN  D/E register: PC+4
//  ValidE           out  1     E slot holds a live instruction
//  RedirectCount    out  CNT_W number of redirects taken, saturating
//  SquashCount      out  CNT_W number of D slots squashed, saturating
// BEHAVIOUR
//  Encoding: opcode=Instr[26:22]; OP_JMP=5'h18 off=sext(Instr[21:0]); OP_BEQ=5'h19, OP_BNE=5'h1A
//   off=sext(Instr[11:0]); all other opcodes non-control, passed through untouched.
//  Target (in D): TgtD = PCD + (off<<2), modulo 2^XLEN (wrap-around, no overflow flag). Registered to PCTargetE.
//  PCSrcE = ValidE & (JmpE | (BeqE & ZeroE) | (BneE & ~ZeroE)); combinational from E regs + ZeroE.
//  Latency: D->E 1 cycle; redirect visible to fetch in the same cycle the instruction sits in E.
//  FSM states RUN, SQUASH; down-counter sq_cnt (clog2(SQUASH_SLOTS+1) bits).
//   RUN: D slot captured with ValidE<=1 unless PCSrcE=1. PCSrcE=1 -> slot captured as bubble,
//     sq_cnt<=SQUASH_SLOTS-1; go SQUASH if SQUASH_SLOTS>1 else stay RUN.
//   SQUASH: every D slot captured as bubble, sq_cnt decrements; at sq_cnt==1 -> RUN next edge.
//  Bubble: InstrE=0, ValidE=0, PCE/PCPlus4E/PCTargetE=0, control decodes 0; guarantees PCSrcE is a
//   single-cycle pulse and no second redirect can occur inside a squash window.
//  SquashCount +1 per bubble inserted by squash; RedirectCount +1 per PCSrcE cycle; both hold at max.
//  Reset (rst=0, async, any state incl. mid-SQUASH): all outputs 0, ValidE=0, PCSrcE=0, FSM RUN,
//   sq_cnt=0, counters 0. First edge after rst=1 captures D as valid.
//  Simultaneous: redirect in E and control instruction in D -> D squashed (E wins); ZeroE is ignored
//   when ValidE=0 or E is non-branch.
// STRUCTURE
//  rida_pkg: XLEN, opcode localparams (OP_NOP/OP_JMP/OP_BEQ/OP_BNE), opcode field slice constants,
//   typedef enum logic {RUN, SQUASH} redir_state_t.
//  Sub-module decode_imm_gen: combinational opcode decode + sign-extended, <<2 offset; rest inline.
// TESTING
//  1 Reset: drive stream, pull rst=0 mid-cycle -> ValidE=0, PCSrcE=0, InstrE/PCE/PCTargetE=0 immediately.
//  2 Straight line: InstrD=ALU op, PCD=0x10, PCPlus4D=0x14 -> next cycle InstrE same, PCE=0x10,
//    PCPlus4E=0x14, ValidE=1, PCSrcE=0.
//  3 JMP at PCD=0x20, off=+4 -> next cycle PCSrcE=1, PCTargetE=0x30; ValidE=0 two cycles,
//    SquashCount=2, RedirectCount=1; instruction at 0x30 arrives ValidE=1.
//  4 BEQ ZeroE=0 -> PCSrcE=0, no squash; BEQ ZeroE=1 -> redirect; BNE ZeroE=1 -> no redirect.
//  5 Wrap: BEQ at PCD=0x4, imm12=0xFFC (-4), ZeroE=1 -> PCTargetE=0x7FFFFF4.
//  6 rst=0 during SQUASH -> FSM RUN, counters 0; after release first D slot captured ValidE=1.

Source files
------------

// File: rtl/rida_pkg.sv
// Shared constants for the decode/redirect slice: instruction field layout,
// control-flow opcodes and the redirect FSM state type.
package rida_pkg;

  localparam int XLEN   = 27;

  localparam int OPC_HI = 26;
  localparam int OPC_LO = 22;
  localparam int OPC_W  = OPC_HI - OPC_LO + 1;
  localparam int JOFF_W = 22;
  localparam int BOFF_W = 12;

  localparam logic [OPC_W-1:0] OP_NOP = 5'h00;
  localparam logic [OPC_W-1:0] OP_JMP = 5'h18;
  localparam logic [OPC_W-1:0] OP_BEQ = 5'h19;
  localparam logic [OPC_W-1:0] OP_BNE = 5'h1A;

  typedef enum logic {RUN, SQUASH} redir_state_t;

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational control-flow decode: classifies the opcode and produces the
// sign-extended, word-scaled branch/jump offset (zero for non-control ops).
module decode_imm_gen
  import rida_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output logic            isJmp,
  output logic            isBeq,
  output logic            isBne,
  output logic [XLEN-1:0] offset
);

  logic [OPC_W-1:0] opcode;
  logic [XLEN-1:0]  jmpOff;
  logic [XLEN-1:0]  brOff;

  assign opcode = instr[OPC_HI:OPC_LO];
  assign jmpOff = {{(XLEN-JOFF_W-2){instr[JOFF_W-1]}}, instr[JOFF_W-1:0], 2'b00};
  assign brOff  = {{(XLEN-BOFF_W-2){instr[BOFF_W-1]}}, instr[BOFF_W-1:0], 2'b00};

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    isJmp  = 1'b0;
    isBeq  = 1'b0;
    isBne  = 1'b0;
    offset = '0;
    case (opcode)
      OP_JMP: begin isJmp = 1'b1; offset = jmpOff; end
      OP_BEQ: begin isBeq = 1'b1; offset = brOff;  end
      OP_BNE: begin isBne = 1'b1; offset = brOff;  end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_redirect.sv
// D/E pipeline register with jump/branch resolution in E. Fetch has no flush,
// so after each redirect the following wrong-path D slots are captured as bubbles.
module decode_redirect
  import rida_pkg::*;
#(
  parameter int SQUASH_SLOTS = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  InstrD,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic             ZeroE,
  output logic             PCSrcE,
  output logic [XLEN-1:0]  PCTargetE,
  output logic [XLEN-1:0]  InstrE,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic             ValidE,
  output logic [CNT_W-1:0] RedirectCount,
  output logic [CNT_W-1:0] SquashCount
);

  localparam int              SQ_W    = $clog2(SQUASH_SLOTS + 1);
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(SQUASH_SLOTS - 1);

  logic            isJmpD;
  logic            isBeqD;
  logic            isBneD;
  logic [XLEN-1:0] offD;
  logic [XLEN-1:0] tgtD;

  logic            jmpE;
  logic            beqE;
  logic            bneE;
  redir_state_t    state;
  logic [SQ_W-1:0] sqCnt;
  logic            squashD;

  decode_imm_gen u_imm_gen (
    .instr  (InstrD),
    .isJmp  (isJmpD),
    .isBeq  (isBeqD),
    .isBne  (isBneD),
    .offset (offD)
  );

  // Target wraps modulo 2^XLEN; there is deliberately no overflow detection.
  assign tgtD = PCD + offD;

  assign PCSrcE  = ValidE & (jmpE | (beqE & ZeroE) | (bneE & ~ZeroE));
  assign squashD = (state == SQUASH) | PCSrcE;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: every register here is plain state (no storage arrays), so all of it is reset.
      state         <= RUN;
      sqCnt         <= '0;
      InstrE        <= '0;
      PCE           <= '0;
      PCPlus4E      <= '0;
      PCTargetE     <= '0;
      ValidE        <= 1'b0;
      jmpE          <= 1'b0;
      beqE          <= 1'b0;
      bneE          <= 1'b0;
      RedirectCount <= '0;
      SquashCount   <= '0;
    end else begin
      if (squashD) begin
        InstrE    <= '0;
        PCE       <= '0;
        PCPlus4E  <= '0;
        PCTargetE <= '0;
        ValidE    <= 1'b0;
        jmpE      <= 1'b0;
        beqE      <= 1'b0;
        bneE      <= 1'b0;
        if (SquashCount != '1) SquashCount <= SquashCount + CNT_W'(1);
      end else begin
        InstrE    <= InstrD;
        PCE       <= PCD;
        PCPlus4E  <= PCPlus4D;
        PCTargetE <= tgtD;
        ValidE    <= 1'b1;
        jmpE      <= isJmpD;
        beqE      <= isBeqD;
        bneE      <= isBneD;
      end

      if (PCSrcE && RedirectCount != '1) RedirectCount <= RedirectCount + CNT_W'(1);

      case (state)
        RUN: begin
          if (PCSrcE) begin
            sqCnt <= SQ_LOAD;
            if (SQUASH_SLOTS > 1) state <= SQUASH;
          end
        end
        SQUASH: begin
          sqCnt <= sqCnt - SQ_W'(1);
          if (sqCnt == SQ_W'(1)) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
